// File: rtl/alu_pkg.sv
// Shared opcode constants and sequencer state encoding for the serial ALU wrapper.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_CMP  = 3'd6;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CAPTURE,
    DONE
  } state_t;

endpackage

// File: rtl/serial_shift_reg.sv
// Parallel-load, shift-right register; serial data enters at the MSB, leaves at the LSB.
// Load wins over shift; one cycle per operation, no backpressure.
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             sin,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {sin, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Feeds a bit-serial ALU LSB-first and collects its result; accept -> out_valid in WIDTH+2 cycles.
// in_ready only in IDLE; result/carry_out held in DONE until out_ready.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [OPW-1:0]   op_in,
  output logic             alu_rst,
  output logic [OPW-1:0]   alu_op,
  output logic             alu_a,
  output logic             alu_b,
  input  logic             alu_y,
  input  logic             alu_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] res_q;
  logic             accept;
  logic             shift_en;
  logic             last_bit;
  logic             unused_bits;

  assign accept   = in_valid && in_ready;
  assign shift_en = (state == SHIFT);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // alu_rst is its own flop so the ALU never sees a decode glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      alu_rst <= 1'b0;
    end else begin
      state   <= state_nxt;
      alu_rst <= (state_nxt == SHIFT);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = CAPTURE;
      CAPTURE: state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    alu_a     = 1'b0;
    alu_b     = 1'b0;
    unique case (state)
      IDLE:  in_ready = 1'b1;
      SHIFT: begin
        alu_a = sa_q[0];
        alu_b = sb_q[0];
      end
      DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // alu_c is sampled in CAPTURE: the ALU has absorbed the last bit but not yet been cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      alu_op    <= '0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      if (accept) begin
        cnt    <= '0;
        alu_op <= op_in;
      end else if (shift_en) begin
        cnt <= cnt + CW'(1);
      end
      if (state == CAPTURE) begin
        result    <= res_q;
        carry_out <= alu_c;
      end
    end
  end

  serial_shift_reg #(.WIDTH(WIDTH)) u_sa (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (shift_en),
    .sin   (1'b0),
    .din   (a_in),
    .q     (sa_q)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_sb (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (shift_en),
    .sin   (1'b0),
    .din   (b_in),
    .q     (sb_q)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_res (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (shift_en),
    .sin   (alu_y),
    .din   ({WIDTH{1'b0}}),
    .q     (res_q)
  );

  assign unused_bits = ^{sa_q[WIDTH-1:1], sb_q[WIDTH-1:1]};

endmodule

// File: tb/tb_alu_serial_seq.sv
// Bench for alu_serial_seq with a bit-serial ALU model attached to the alu_* ports.
module tb_alu_serial_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in, b_in;
  logic [2:0]   op_in;
  logic         alu_rst;
  logic [2:0]   alu_op;
  logic         alu_a, alu_b, alu_y, alu_c;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_serial_seq #(.WIDTH(W), .OPW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .op_in     (op_in),
    .alu_rst   (alu_rst),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_y     (alu_y),
    .alu_c     (alu_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out)
  );

  // Serial ALU: y is combinational, the flag register clears synchronously while alu_rst is low.
  logic alu_cn;
  always_comb begin
    alu_y  = 1'b0;
    alu_cn = alu_c;
    case (alu_op)
      OP_ADD:  begin alu_y = alu_a ^ alu_b ^ alu_c; alu_cn = (alu_a & alu_b) | (alu_c & (alu_a ^ alu_b)); end
      OP_SUB:  begin alu_y = alu_a ^ alu_b ^ alu_c; alu_cn = (~alu_a & alu_b) | (~(alu_a ^ alu_b) & alu_c); end
      OP_OR:   begin alu_y = alu_a | alu_b;    alu_cn = alu_c | alu_y; end
      OP_AND:  begin alu_y = alu_a & alu_b;    alu_cn = alu_c | alu_y; end
      OP_XOR:  begin alu_y = alu_a ^ alu_b;    alu_cn = alu_c | alu_y; end
      OP_XNOR: begin alu_y = ~(alu_a ^ alu_b); alu_cn = alu_c | alu_y; end
      OP_CMP:  begin alu_y = alu_a ^ alu_b;    alu_cn = (alu_a & ~alu_b) | (~(alu_a ^ alu_b) & alu_c); end
      default: ;
    endcase
  end
  always @(posedge clk) begin
    if (!alu_rst) alu_c <= 1'b0;
    else          alu_c <= alu_cn;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference: whole-word arithmetic. SUB flag = borrow, CMP flag = a>b, logic flag = nonzero.
  function automatic logic [W:0] ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c;
    s = '0;
    r = '0;
    c = 1'b0;
    case (op)
      OP_ADD:  begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W]; end
      OP_SUB:  begin r = a - b;    c = (a < b); end
      OP_OR:   begin r = a | b;    c = (r != 0); end
      OP_AND:  begin r = a & b;    c = (r != 0); end
      OP_XOR:  begin r = a ^ b;    c = (r != 0); end
      OP_XNOR: begin r = ~(a ^ b); c = (r != 0); end
      OP_CMP:  begin r = a ^ b;    c = (a > b); end
      default: ;
    endcase
    return {c, r};
  endfunction

  // Timeline model: after accept at cycle t0, alu_rst high for t0+1..t0+W, out_valid from t0+W+2.
  bit         m_busy = 1'b0;
  bit         seen_done;
  int         m_t0, hi_cnt;
  logic [W-1:0] m_a, m_b;
  logic [2:0] m_op;
  logic [W:0] m_exp;
  logic       exp_rdy, exp_ar, exp_ov;

  always @(negedge clk) begin
    if (!rst) begin
      m_busy = 1'b0;
    end else begin
      exp_rdy = !m_busy;
      exp_ar  = m_busy && (cyc > m_t0) && (cyc <= m_t0 + W);
      exp_ov  = m_busy && (cyc >= m_t0 + W + 2);
      chk("handshake_timing {in_ready,alu_rst,out_valid}", {29'd0, in_ready, alu_rst, out_valid},
          {29'd0, exp_rdy, exp_ar, exp_ov});
      if (alu_rst) hi_cnt++;
      if (m_busy) chk("alu_op", alu_op, m_op);
      if (exp_ar) chk("serial_bits", {alu_a, alu_b}, {m_a[cyc-m_t0-1], m_b[cyc-m_t0-1]});
      else        chk("serial_idle_zero", {alu_a, alu_b}, 2'b00);
      if (exp_ov) begin
        chk("model_carry", carry_out, m_exp[W]);
        if (m_op != OP_CMP) chk("model_result", result, m_exp[W-1:0]);
        if (!seen_done) begin
          chk("alu_rst_high_cycles", hi_cnt, W);
          seen_done = 1'b1;
        end
      end
      if (exp_rdy && in_valid) begin
        m_busy = 1'b1; m_t0 = cyc; m_a = a_in; m_b = b_in; m_op = op_in;
        m_exp = ref_op(op_in, a_in, b_in);
        hi_cnt = 0; seen_done = 1'b0;
      end else if (exp_ov && out_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  task automatic drive_req(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output int acc_cyc);
    bit ok;
    ok = 1'b0;
    acc_cyc = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; op_in = op; a_in = a; b_in = b;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; acc_cyc = cyc; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk("out_valid_timeout", 0, 1);
  endtask

  int acc;

  initial begin
    rst = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0; op_in = '0; out_ready = 1'b1;
    #12;
    chk("reset_outputs {in_ready,out_valid,alu_rst,carry_out}",
        {in_ready, out_valid, alu_rst, carry_out}, 4'b1000);
    chk("reset_result", result, 0);
    chk("reset_alu_op", alu_op, 0);
    @(posedge clk); #2; rst = 1'b1;

    // ADD 200+100 = 300 -> 0x2C carry 1, out_valid 10 cycles after accept
    drive_req(OP_ADD, 8'd200, 8'd100, acc);
    @(negedge clk); wait_out();
    chk("add_latency", cyc - acc, W + 2);
    chk("add_result", result, 8'h2C);
    chk("add_carry", carry_out, 1);

    // Back-to-back SUB then XNOR
    drive_req(OP_SUB, 8'd5, 8'd3, acc);
    @(negedge clk); wait_out();
    chk("sub_result", result, 8'h02);
    chk("sub_carry", carry_out, 0);
    @(negedge clk);
    chk("ready_after_done", in_ready, 1);
    drive_req(OP_XNOR, 8'hA5, 8'hA5, acc);
    @(negedge clk); wait_out();
    chk("xnor_result", result, 8'hFF);
    chk("xnor_carry", carry_out, 1);

    // Compare
    drive_req(OP_CMP, 8'd7, 8'd3, acc);
    @(negedge clk); wait_out();
    chk("cmp_gt_carry", carry_out, 1);
    drive_req(OP_CMP, 8'd3, 8'd7, acc);
    @(negedge clk); wait_out();
    chk("cmp_lt_carry", carry_out, 0);

    // Backpressure: result held, in_valid pulses ignored
    @(negedge clk);
    out_ready = 1'b0;
    drive_req(OP_OR, 8'h0F, 8'hF0, acc);
    @(negedge clk); wait_out();
    for (int i = 0; i < 5; i++) begin
      chk("bp_result", result, 8'hFF);
      chk("bp_carry", carry_out, 1);
      chk("bp_hold {in_ready,out_valid}", {in_ready, out_valid}, 2'b01);
      @(posedge clk); #1;
      in_valid = i[0]; op_in = OP_SUB; a_in = 8'h11; b_in = 8'h22;
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1);

    // Asynchronous reset in SHIFT cycle 4
    drive_req(OP_AND, 8'hFF, 8'h3C, acc);
    repeat (3) @(posedge clk);
    #3; rst = 1'b0; #1;
    chk("abort_flags {in_ready,out_valid,alu_rst,carry_out}",
        {in_ready, out_valid, alu_rst, carry_out}, 4'b1000);
    chk("abort_result", result, 0);
    chk("abort_alu_op", alu_op, 0);
    chk("abort_serial", {alu_a, alu_b}, 2'b00);
    repeat (2) @(posedge clk);
    #2; rst = 1'b1;

    drive_req(OP_AND, 8'hFF, 8'h3C, acc);
    @(negedge clk); wait_out();
    chk("and_latency", cyc - acc, W + 2);
    chk("and_result", result, 8'h3C);
    chk("and_carry", carry_out, 1);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
- Sequencer wrapped around the bit-serial ALU; acts as its upstream feeder and downstream collector.
- Accepts parallel operands and an opcode via a valid/ready handshake, then drives the ALU's active-low reset.
- Shifts operand bits into the ALU LSB-first, one per clock, and gathers y back into a parallel result.
- Captures the final carry and presents result and carry via a valid/ready handshake.

Parameters:
- WIDTH, 8: operand/result width in bits; the serial pass lasts WIDTH cycles.
- OPW, 3: opcode width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset (0 = reset).
- in_valid  in  1  operand request valid.
- in_ready  out  1  sequencer can accept a request.
- a_in  in  WIDTH  operand A.
- b_in  in  WIDTH  operand B.
- op_in  in  OPW  ALU opcode.
- alu_rst  out  1  active-low reset to the ALU; clears ALU carry state.
- alu_op  out  OPW  opcode to the ALU.
- alu_a  out  1  serial A bit.
- alu_b  out  1  serial B bit.
- alu_y  in  1  serial result bit from the ALU (combinational on the current bits and the ALU carry).
- alu_c  in  1  registered carry/flag from the ALU.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  parallel result.
- carry_out  out  1  final ALU carry/flag.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst.
  - While rst=0: state=IDLE, counter=0, shift registers=0, result=0, carry_out=0, alu_op=0, out_valid=0, alu_rst=0.
- States:
  - IDLE: in_ready=1, alu_rst=0. On in_valid&&in_ready: load sa<=a_in, sb<=b_in, alu_op<=op_in, cnt<=0, go to SHIFT.
  - SHIFT: alu_rst=1, alu_a=sa[0], alu_b=sb[0]. Each clock: sa, sb shift right with zero fill; res<={alu_y,res[WIDTH-1:1]}; cnt++. When cnt==WIDTH-1, go to CAPTURE.
  - CAPTURE: one cycle, alu_rst=0, alu_a=alu_b=0. alu_c now holds the carry after all WIDTH bits. At the closing edge: carry_out<=alu_c, result<=res, go to DONE.
  - DONE: out_valid=1, alu_rst=0. result and carry_out are held stable until out_ready=1, then go to IDLE.
- Outputs and latency:
  - alu_op stays stable from accept until the next accept.
  - in_ready=1 only in IDLE, so no new request is accepted while a result is pending.
  - Accept at edge k gives SHIFT cycles k+1..k+WIDTH, CAPTURE at cycle k+WIDTH+1, and out_valid=1 from cycle k+WIDTH+2.
  - Minimum issue interval is WIDTH+3 cycles, with out_ready tied high.
- Boundary conditions:
  - Counter width is $clog2(WIDTH+1); no wrap occurs within an operation.
  - in_valid asserted outside IDLE is ignored; the request is not consumed.
  - Opcode 7 is passed through unchecked; result is ALU-defined.
  - Opcode 6 (compare): only carry_out is meaningful.
  - rst low mid-SHIFT or mid-DONE aborts immediately and the pending result is lost. The first request after reset release is handled normally.
  - out_ready asserted in a non-DONE state has no effect.
  - alu_rst is driven purely from the state register (glitch-free), and is never high outside SHIFT.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants: OP_ADD=0, OP_SUB=1, OP_OR=2, OP_AND=3, OP_XOR=4, OP_XNOR=5, OP_CMP=6.
  - State enum {IDLE, SHIFT, CAPTURE, DONE}.
- One natural sub-module, serial_shift_reg: parallel-load, shift-right register parameterised by WIDTH. It is instantiated three times: sa and sb as parallel-in/serial-out, res as serial-in/parallel-out.
- The ALU itself stays outside this block. The bench connects the existing alu to the alu_* ports.

Test Plan:
- OP_ADD, a=200, b=100 -> result=44 (0x2C), carry_out=1, out_valid exactly WIDTH+2=10 cycles after accept.
- OP_SUB, a=5, b=3 -> result=2. Then OP_XNOR, a=b=0xA5 -> result=0xFF, carry_out=1. Issue back-to-back with out_ready=1; in_ready reasserts the cycle after the DONE handshake.
- OP_CMP, a=7, b=3 -> carry_out=1. Then a=3, b=7 -> carry_out=0.
- Backpressure, OP_OR, a=0x0F, b=0xF0: hold out_ready=0 for 5 cycles -> result=0xFF and carry_out=1 held stable; in_ready=0 and in_valid pulses ignored; completes when out_ready=1.
- Drive rst low at SHIFT cycle 4 of OP_AND, a=0xFF, b=0x3C -> all outputs reach their reset values asynchronously. After release, a new OP_AND, a=0xFF, b=0x3C -> result=0x3C, carry_out=1.
- Throughout every test, check alu_rst=0 in all non-SHIFT cycles and exactly WIDTH cycles of alu_rst=1 per operation.
